// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared state codes and port ids for the data-memory port arbiter
package dmem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_MA = 1'b1;
endpackage

// File: rtl/dmem_port_arbiter_lat_timer.sv
// dmem_port_arbiter_lat_timer: 3-bit loadable down-counter with zero flag timing the memory read latency
module dmem_port_arbiter_lat_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [2:0] cnt;
  // load on command issue, count down while waiting, stop at zero
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != 3'd0) cnt <= cnt - 3'd1;
  assign zero = cnt == 3'd0;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port memory between IF and MA with MA priority and an IF starvation guard
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic              ma_gnt,
  output logic              ma_rvalid,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("dmem_port_arbiter: MEM_LAT=%0d outside 1..7", MEM_LAT);
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve
    $error("dmem_port_arbiter: STARVE_MAX=%0d outside 1..7", STARVE_MAX);
  end

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t            state, state_nx;
  logic              port_q, we_q, lat_zero, arb, gnt_if_w, gnt_ma_w, any_gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        starve_q;

  assign arb      = (state == ST_IDLE || state == ST_RESP) && !rst;
  assign gnt_if_w = arb && if_req && (!ma_req || starve_q == SMAX);
  assign gnt_ma_w = arb && ma_req && !gnt_if_w;
  assign any_gnt  = gnt_if_w || gnt_ma_w;

  dmem_port_arbiter_lat_timer u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_CMD),
    .load_val (LAT_LOAD),
    .dec      (state == ST_WAIT),
    .zero     (lat_zero)
  );

  // next-state: one command cycle, reads wait out the latency then respond
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: state_nx = any_gnt ? ST_CMD : ST_IDLE;
      ST_CMD:  state_nx = we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: state_nx = lat_zero ? ST_RESP : ST_WAIT;
      ST_RESP: state_nx = any_gnt ? ST_CMD : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // state, latched command, starvation count and per-port read data
  always_ff @(posedge clk)
    if (rst) begin
      state    <= ST_IDLE;
      port_q   <= PORT_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      if_rdata <= '0;
      ma_rdata <= '0;
    end else begin
      state <= state_nx;
      if (any_gnt) begin
        port_q  <= gnt_ma_w ? PORT_MA : PORT_IF;
        we_q    <= gnt_ma_w && ma_we;
        addr_q  <= gnt_ma_w ? ma_addr : if_addr;
        wdata_q <= gnt_ma_w ? ma_wdata : '0;
      end
      if (state == ST_WAIT && lat_zero && port_q == PORT_MA) ma_rdata <= mem_rdata;
      if (state == ST_WAIT && lat_zero && port_q == PORT_IF) if_rdata <= mem_rdata;
      starve_q <= (!if_req || gnt_if_w) ? 3'd0 : (gnt_ma_w && starve_q != SMAX) ? starve_q + 3'd1 : starve_q;
    end

  assign if_gnt    = gnt_if_w;
  assign ma_gnt    = gnt_ma_w;
  assign if_rvalid = state == ST_RESP && port_q == PORT_IF;
  assign ma_rvalid = state == ST_RESP && port_q == PORT_MA;
  assign mem_en    = state == ST_CMD;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign busy      = state != ST_IDLE;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of the arbiter at MEM_LAT=1 (dut 0) and MEM_LAT=3 (dut 1)
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        if_req [2], if_gnt [2], if_rvalid [2];
  logic [11:0] if_addr [2], if_rdata [2];
  logic        ma_req [2], ma_we [2], ma_gnt [2], ma_rvalid [2];
  logic [11:0] ma_addr [2], ma_wdata [2], ma_rdata [2];
  logic        mem_en [2], mem_we [2], busy [2];
  logic [11:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic        ovr [2];
  logic [11:0] ovr_val [2];
  bit   [11:0] mac [2][4096];
  bit   [11:0] pipe [2][3];
  int          pass_cnt = 0, chk_cnt = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_port_arbiter #(.MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(3)) dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ma_req(ma_req[g]), .ma_we(ma_we[g]), .ma_addr(ma_addr[g]), .ma_wdata(ma_wdata[g]),
      .ma_gnt(ma_gnt[g]), .ma_rvalid(ma_rvalid[g]), .ma_rdata(ma_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
  end

  // memory macro model: read data appears MEM_LAT cycles after mem_en, random junk otherwise
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] && mem_we[d]) mac[d][mem_addr[d]] <= mem_wdata[d];
      pipe[d][0] <= (mem_en[d] && !mem_we[d]) ? mac[d][mem_addr[d]] : 12'($urandom);
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  assign mem_rdata[0] = ovr[0] ? ovr_val[0] : pipe[0][0];
  assign mem_rdata[1] = ovr[1] ? ovr_val[1] : pipe[1][2];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr(input int d);
    if_req[d] = 0; if_addr[d] = 0; ma_req[d] = 0; ma_we[d] = 0;
    ma_addr[d] = 0; ma_wdata[d] = 0; ovr[d] = 0; ovr_val[d] = 0;
  endtask

  task automatic reset_dut(input int d);
    clr(d);
    rst[d] = 1;
    step();
    rst[d] = 0;
  endtask

  task automatic run_read(input int d, input bit ma, input logic [11:0] addr, input logic [11:0] val);
    int lat = d ? 3 : 1;
    if (ma) begin ma_req[d] = 1; ma_we[d] = 0; ma_addr[d] = addr; end
    else begin if_req[d] = 1; if_addr[d] = addr; end
    #1;
    chk_cnt++;
    if ((ma ? ma_gnt[d] : if_gnt[d]) !== 1'b1) $display("FAIL rd_gnt d%0d ma=%0b: gnt=%b expected 1", d, ma, ma ? ma_gnt[d] : if_gnt[d]);
    else pass_cnt++;
    step();
    if_req[d] = 0; ma_req[d] = 0;
    #1;
    chk_cnt++;
    if ({mem_en[d], mem_we[d], mem_addr[d]} !== {2'b10, addr}) $display("FAIL rd_cmd d%0d: en/we/addr=%b/%b/%h expected 1/0/%h", d, mem_en[d], mem_we[d], mem_addr[d], addr);
    else pass_cnt++;
    repeat (lat) step();
    ovr[d] = 1; ovr_val[d] = val;
    step();
    ovr[d] = 0;
    #1;
    chk_cnt++;
    if ({(ma ? ma_rvalid[d] : if_rvalid[d]), (ma ? ma_rdata[d] : if_rdata[d])} !== {1'b1, val})
      $display("FAIL rd_resp d%0d ma=%0b: rvalid/rdata=%b/%h expected 1/%h", d, ma, ma ? ma_rvalid[d] : if_rvalid[d], ma ? ma_rdata[d] : if_rdata[d], val);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      clr(d);
      rst[d] = 1;
      step(); step();
      rst[d] = 0;
      #1;
      chk_cnt++;
      if ({if_gnt[d], ma_gnt[d], if_rvalid[d], ma_rvalid[d], if_rdata[d], ma_rdata[d], mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], busy[d]} !== '0)
        $display("FAIL reset d%0d: busy=%b mem_en=%b if_rdata=%h ma_rdata=%h expected all 0", d, busy[d], mem_en[d], if_rdata[d], ma_rdata[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_if_read();
    reset_dut(0);
    if_req[0] = 1; if_addr[0] = 12'h010;
    #1;
    chk_cnt++;
    if ({if_gnt[0], ma_gnt[0]} !== 2'b10) $display("FAIL t1_gnt: if/ma gnt=%b/%b expected 1/0", if_gnt[0], ma_gnt[0]);
    else pass_cnt++;
    step();
    if_req[0] = 0;
    #1;
    chk_cnt++;
    if ({mem_en[0], mem_we[0], mem_addr[0], busy[0]} !== {2'b10, 12'h010, 1'b1}) $display("FAIL t1_cmd: en/we/addr/busy=%b/%b/%h/%b expected 1/0/010/1", mem_en[0], mem_we[0], mem_addr[0], busy[0]);
    else pass_cnt++;
    step();
    ovr[0] = 1; ovr_val[0] = 12'hABC;
    #1;
    chk_cnt++;
    if ({if_rvalid[0], mem_en[0], mem_addr[0]} !== '0) $display("FAIL t1_wait: rvalid/en/addr=%b/%b/%h expected 0/0/000", if_rvalid[0], mem_en[0], mem_addr[0]);
    else pass_cnt++;
    step();
    ovr[0] = 0;
    #1;
    chk_cnt++;
    if ({if_rvalid[0], if_rdata[0], ma_rvalid[0]} !== {1'b1, 12'hABC, 1'b0}) $display("FAIL t1_resp: rvalid/rdata=%b/%h expected 1/abc", if_rvalid[0], if_rdata[0]);
    else pass_cnt++;
    step();
    #1;
    chk_cnt++;
    if ({busy[0], if_rvalid[0], if_rdata[0]} !== {2'b00, 12'hABC}) $display("FAIL t1_idle: busy/rvalid/rdata=%b/%b/%h expected 0/0/abc", busy[0], if_rvalid[0], if_rdata[0]);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    reset_dut(0);
    if_req[0] = 1; if_addr[0] = 12'h055;
    ma_req[0] = 1; ma_we[0] = 0; ma_addr[0] = 12'h200;
    #1;
    chk_cnt++;
    if ({ma_gnt[0], if_gnt[0]} !== 2'b10) $display("FAIL t2_gnt0: ma/if gnt=%b/%b expected 1/0", ma_gnt[0], if_gnt[0]);
    else pass_cnt++;
    step();
    ma_req[0] = 0;
    #1;
    chk_cnt++;
    if ({if_gnt[0], mem_en[0], mem_addr[0]} !== {2'b01, 12'h200}) $display("FAIL t2_cmd: if_gnt/en/addr=%b/%b/%h expected 0/1/200", if_gnt[0], mem_en[0], mem_addr[0]);
    else pass_cnt++;
    step();
    ovr[0] = 1; ovr_val[0] = 12'h3C5;
    #1;
    chk_cnt++;
    if (if_gnt[0] !== 1'b0) $display("FAIL t2_wait_gnt: if_gnt=%b expected 0", if_gnt[0]);
    else pass_cnt++;
    step();
    ovr[0] = 0;
    #1;
    chk_cnt++;
    if ({if_gnt[0], ma_rvalid[0], ma_rdata[0]} !== {2'b11, 12'h3C5}) $display("FAIL t2_resp: if_gnt/ma_rvalid/ma_rdata=%b/%b/%h expected 1/1/3c5", if_gnt[0], ma_rvalid[0], ma_rdata[0]);
    else pass_cnt++;
    step();
    if_req[0] = 0;
    #1;
    chk_cnt++;
    if ({mem_en[0], mem_addr[0]} !== {1'b1, 12'h055}) $display("FAIL t2_cmd2: en/addr=%b/%h expected 1/055", mem_en[0], mem_addr[0]);
    else pass_cnt++;
    step(); step(); step();
    clr(0);
  endtask

  task automatic test_starvation();
    int ng = 0;
    reset_dut(0);
    for (int c = 0; c < 80 && ng < 9; c++) begin
      if_req[0] = 1; if_addr[0] = 12'h0A0;
      ma_req[0] = 1; ma_we[0] = 1; ma_addr[0] = 12'(c); ma_wdata[0] = 12'(c * 3);
      #1;
      chk_cnt++;
      if (if_gnt[0] && ma_gnt[0]) $display("FAIL t3_both_gnt: cycle %0d both gnt high expected at most one", c);
      else pass_cnt++;
      if (if_gnt[0] || ma_gnt[0]) begin
        chk_cnt++;
        if (if_gnt[0] !== (ng == 3 || ng == 7)) $display("FAIL t3_order: grant %0d if_gnt=%b expected %b", ng, if_gnt[0], ng == 3 || ng == 7);
        else pass_cnt++;
        ng++;
      end
      step();
    end
    chk_cnt++;
    if (ng != 9) $display("FAIL t3_count: saw %0d grants expected 9", ng);
    else pass_cnt++;
    clr(0);
    repeat (4) step();
  endtask

  task automatic test_write();
    reset_dut(0);
    ma_req[0] = 1; ma_we[0] = 1; ma_addr[0] = 12'h123; ma_wdata[0] = 12'h456;
    #1;
    chk_cnt++;
    if (ma_gnt[0] !== 1'b1) $display("FAIL t4_gnt: ma_gnt=%b expected 1", ma_gnt[0]);
    else pass_cnt++;
    step();
    ma_addr[0] = 12'h124; ma_wdata[0] = 12'h111;
    #1;
    chk_cnt++;
    if ({ma_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]} !== {3'b011, 12'h123, 12'h456})
      $display("FAIL t4_cmd: gnt/en/we/addr/wdata=%b/%b/%b/%h/%h expected 0/1/1/123/456", ma_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    else pass_cnt++;
    step();
    #1;
    chk_cnt++;
    if ({ma_gnt[0], ma_rvalid[0]} !== 2'b10) $display("FAIL t4_regnt: ma_gnt/ma_rvalid=%b/%b expected 1/0", ma_gnt[0], ma_rvalid[0]);
    else pass_cnt++;
    step();
    ma_req[0] = 0;
    #1;
    chk_cnt++;
    if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], ma_rvalid[0]} !== {2'b11, 12'h124, 12'h111, 1'b0})
      $display("FAIL t4_cmd2: en/we/addr/wdata/rvalid=%b/%b/%h/%h/%b expected 1/1/124/111/0", mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], ma_rvalid[0]);
    else pass_cnt++;
    step();
    #1;
    chk_cnt++;
    if ({ma_rvalid[0], busy[0], mem_wdata[0]} !== '0) $display("FAIL t4_idle: rvalid/busy/wdata=%b/%b/%h expected 0/0/000", ma_rvalid[0], busy[0], mem_wdata[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    reset_dut(1);
    run_read(1, 1, 12'h300, 12'h9D1);
    step();
    if_req[1] = 1; if_addr[1] = 12'h077;
    #1;
    chk_cnt++;
    if (if_gnt[1] !== 1'b1) $display("FAIL t5_gnt: if_gnt=%b expected 1", if_gnt[1]);
    else pass_cnt++;
    step();
    if_req[1] = 0;
    step();
    rst[1] = 1;
    step();
    rst[1] = 0;
    #1;
    chk_cnt++;
    if ({if_gnt[1], ma_gnt[1], if_rvalid[1], ma_rvalid[1], if_rdata[1], ma_rdata[1], mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1], busy[1]} !== '0)
      $display("FAIL t5_zero: busy=%b ma_rdata=%h if_rdata=%h rvalid=%b expected all 0", busy[1], ma_rdata[1], if_rdata[1], if_rvalid[1]);
    else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      step();
      #1;
      chk_cnt++;
      if ({if_rvalid[1], ma_rvalid[1], busy[1]} !== 3'b000) $display("FAIL t5_dropped: cycle %0d rvalid/busy=%b/%b expected 0/0", c, if_rvalid[1], busy[1]);
      else pass_cnt++;
    end
    run_read(1, 0, 12'h078, 12'h6E4);
    step();
  endtask

  task automatic test_back_to_back();
    bit ip = 1, mp = 1;
    reset_dut(1);
    for (int c = 0; c < 13; c++) begin
      if_req[1] = ip; if_addr[1] = 12'h0F0;
      ma_req[1] = mp; ma_we[1] = 0; ma_addr[1] = 12'h1F0;
      ovr[1] = (c == 4 || c == 9); ovr_val[1] = (c == 4) ? 12'h2AA : 12'h3BB;
      #1;
      chk_cnt++;
      if ({ma_gnt[1], if_gnt[1]} !== {c == 0, c == 5}) $display("FAIL t6_gnt: cycle %0d ma/if gnt=%b/%b expected %b/%b", c, ma_gnt[1], if_gnt[1], c == 0, c == 5);
      else pass_cnt++;
      chk_cnt++;
      if ({ma_rvalid[1], if_rvalid[1]} !== {c == 5, c == 10}) $display("FAIL t6_rvalid: cycle %0d ma/if rvalid=%b/%b expected %b/%b", c, ma_rvalid[1], if_rvalid[1], c == 5, c == 10);
      else pass_cnt++;
      chk_cnt++;
      if ({ma_rdata[1], if_rdata[1]} !== {(c >= 5 ? 12'h2AA : 12'h000), (c >= 10 ? 12'h3BB : 12'h000)})
        $display("FAIL t6_rdata: cycle %0d ma/if rdata=%h/%h", c, ma_rdata[1], if_rdata[1]);
      else pass_cnt++;
      if (ma_gnt[1]) mp = 0;
      if (if_gnt[1]) ip = 0;
      step();
    end
    clr(1);
  endtask

  task automatic test_random(input int d, input int n);
    int lat = d ? 3 : 1;
    int now = 0, free_at = 0, cmd_at = -1, resp_at = -1, starve = 0;
    bit ih = 0, mh = 0, mwe = 0, p_port = 0, c_we = 0, free, e_ig, e_mg, e_irv, e_mrv, e_en;
    logic [11:0] ia = 0, ma = 0, mwd = 0, p_data = 0, c_addr = 0, c_wdata = 0, e_ird = 0, e_mrd = 0;
    logic [11:0] shadow [4096];
    reset_dut(d);
    for (int a = 0; a < 4096; a++) shadow[a] = mac[d][a];
    for (int i = 0; i < n; i++) begin
      if (!ih && $urandom_range(0, 2) == 0) begin ih = 1; ia = 12'($urandom_range(0, 31)); end
      else if (ih && $urandom_range(0, 9) == 0) ih = 0;
      if (!mh && $urandom_range(0, 2) == 0) begin
        mh = 1; mwe = 1'($urandom_range(0, 1)); ma = 12'($urandom_range(0, 31)); mwd = 12'($urandom);
      end else if (mh && $urandom_range(0, 9) == 0) mh = 0;
      if_req[d] = ih; if_addr[d] = ia;
      ma_req[d] = mh; ma_we[d] = mwe; ma_addr[d] = ma; ma_wdata[d] = mwd;
      #1;
      free  = now >= free_at;
      e_ig  = free && ih && (!mh || starve == 3);
      e_mg  = free && mh && !e_ig;
      e_irv = now == resp_at && p_port == 0;
      e_mrv = now == resp_at && p_port == 1;
      e_en  = now == cmd_at;
      if (e_irv) e_ird = p_data;
      if (e_mrv) e_mrd = p_data;
      chk_cnt++;
      if ({if_gnt[d], ma_gnt[d]} !== {e_ig, e_mg}) $display("FAIL rnd_gnt d%0d cyc %0d: if/ma gnt=%b/%b expected %b/%b", d, now, if_gnt[d], ma_gnt[d], e_ig, e_mg);
      else pass_cnt++;
      chk_cnt++;
      if ({if_rvalid[d], ma_rvalid[d], if_rdata[d], ma_rdata[d]} !== {e_irv, e_mrv, e_ird, e_mrd})
        $display("FAIL rnd_resp d%0d cyc %0d: rv=%b/%b rd=%h/%h expected %b/%b %h/%h", d, now, if_rvalid[d], ma_rvalid[d], if_rdata[d], ma_rdata[d], e_irv, e_mrv, e_ird, e_mrd);
      else pass_cnt++;
      chk_cnt++;
      if ({mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d]} !== {e_en, e_en && c_we, (e_en ? c_addr : 12'h000), (e_en && c_we ? c_wdata : 12'h000)})
        $display("FAIL rnd_mem d%0d cyc %0d: en/we/addr/wdata=%b/%b/%h/%h expected %b/%b/%h/%h", d, now, mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], e_en, e_en && c_we, e_en ? c_addr : 12'h000, e_en && c_we ? c_wdata : 12'h000);
      else pass_cnt++;
      chk_cnt++;
      if (busy[d] !== (now < free_at || now == resp_at)) $display("FAIL rnd_busy d%0d cyc %0d: busy=%b expected %b", d, now, busy[d], now < free_at || now == resp_at);
      else pass_cnt++;
      if (!ih || e_ig) starve = 0;
      else if (e_mg && starve < 3) starve++;
      if (e_ig || e_mg) begin
        cmd_at  = now + 1;
        c_we    = e_mg && mwe;
        c_addr  = e_mg ? ma : ia;
        c_wdata = mwd;
        if (c_we) begin
          shadow[c_addr] = c_wdata;
          free_at = now + 2;
          resp_at = -1;
        end else begin
          p_port  = e_mg;
          p_data  = shadow[c_addr];
          resp_at = now + 2 + lat;
          free_at = resp_at;
        end
        if (e_ig) ih = 0;
        else mh = 0;
      end
      step();
      now++;
    end
    clr(d);
    repeat (8) step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin clr(d); rst[d] = 1; end
    step(); step();
    for (int d = 0; d < 2; d++) rst[d] = 0;
    test_reset();
    test_if_read();
    test_simultaneous();
    test_starvation();
    test_write();
    test_reset_mid_read();
    test_back_to_back();
    test_random(0, 400);
    test_random(1, 400);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog timeout");
  end
endmodule
